// File: rtl/crop_writer.sv
// Captures the in-box pixels of one raster frame and packs them, raster order from
// address 0, into a crop BRAM write port. Optional macro: CROP_WRITER_DECIMATE2_EN.
module crop_writer #(
    parameter int WIDTH      = 240,
    parameter int HEIGHT     = 320,
    parameter int CROP_DEPTH = 4096,
    localparam int AW = $clog2(CROP_DEPTH),
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    input  logic [XW-1:0] left_edge,
    input  logic [XW-1:0] right_edge,
    input  logic [YW-1:0] top_edge,
    input  logic [YW-1:0] bot_edge,
    input  logic [XW-1:0] hcount_in,
    input  logic [YW-1:0] vcount_in,
    input  logic          valid_in,
    input  logic [15:0]   pixel_in,
    output logic [AW-1:0] wr_addr_out,
    output logic [15:0]   wr_data_out,
    output logic          wr_en_out,
    output logic          busy_out,
    output logic          done_out,
    output logic          error_out,
    output logic          overflow_out,
    output logic [XW:0]   crop_w_out,
    output logic [YW:0]   crop_h_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(CROP_DEPTH);

    function automatic logic in_box(input logic [XW-1:0] h, input logic [XW-1:0] lo_h,
                                    input logic [XW-1:0] hi_h, input logic [YW-1:0] v,
                                    input logic [YW-1:0] lo_v, input logic [YW-1:0] hi_v);
        return (h >= lo_h) && (h <= hi_h) && (v >= lo_v) && (v <= hi_v);
    endfunction

    state_t        state_r, state_s;
    logic [XW-1:0] left_r, right_r;
    logic [YW-1:0] top_r, bot_r;
    logic [AW:0]   ptr_r;
    logic [AW-1:0] wr_addr_r;
    logic [15:0]   wr_data_r;
    logic          wr_en_r, busy_r, done_r, error_r, overflow_r;
    logic [XW:0]   crop_w_r, crop_w_s, w_span_s;
    logic [YW:0]   crop_h_r, crop_h_s, h_span_s;

    logic frame_start_s, start_ok_s, start_acc_s, eval_s, abort_s;
    logic keep_s, take_s, last_s, wr_s, ovf_s;
    logic busy_s, done_s, error_s;

    // Beat classification against the latched box.
    always_comb begin
        frame_start_s = valid_in && (hcount_in == {XW{1'b0}}) && (vcount_in == {YW{1'b0}});
        start_ok_s    = (right_edge >= left_edge) && (bot_edge >= top_edge);
        start_acc_s   = (state_r == S_IDLE) && start_in && start_ok_s;
        // The frame-start beat that arms the capture is itself a capture pixel.
        eval_s  = ((state_r == S_ARMED) && frame_start_s) ||
                  ((state_r == S_CAPTURE) && valid_in && !frame_start_s);
        abort_s = (state_r == S_CAPTURE) && frame_start_s;
`ifdef CROP_WRITER_DECIMATE2_EN
        keep_s = !(hcount_in[0] ^ left_r[0]) && !(vcount_in[0] ^ top_r[0]);
`else
        keep_s = 1'b1;
`endif
        take_s = eval_s && keep_s && in_box(hcount_in, left_r, right_r, vcount_in, top_r, bot_r);
        last_s = eval_s && (hcount_in == right_r) && (vcount_in == bot_r);
        wr_s   = take_s && (ptr_r < DEPTH_L);
        ovf_s  = take_s && !(ptr_r < DEPTH_L);
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_acc_s) state_s = S_ARMED;
                else             state_s = S_IDLE;
            end
            S_ARMED: begin
                if (frame_start_s) state_s = last_s ? S_FINISH : S_CAPTURE;
                else               state_s = S_ARMED;
            end
            S_CAPTURE: begin
                if (abort_s)     state_s = S_IDLE;
                else if (last_s) state_s = S_FINISH;
                else             state_s = S_CAPTURE;
            end
            S_FINISH: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Output decode; values are registered one cycle later alongside the write.
    always_comb begin
        busy_s   = (state_s == S_ARMED) || (state_s == S_CAPTURE);
        done_s   = (state_s == S_FINISH);
        error_s  = ((state_r == S_IDLE) && start_in && !start_ok_s) || abort_s;
        w_span_s = {1'b0, right_edge} - {1'b0, left_edge};
        h_span_s = {1'b0, bot_edge} - {1'b0, top_edge};
`ifdef CROP_WRITER_DECIMATE2_EN
        crop_w_s = {1'b0, w_span_s[XW:1]} + {{XW{1'b0}}, 1'b1};
        crop_h_s = {1'b0, h_span_s[YW:1]} + {{YW{1'b0}}, 1'b1};
`else
        crop_w_s = w_span_s + {{XW{1'b0}}, 1'b1};
        crop_h_s = h_span_s + {{YW{1'b0}}, 1'b1};
`endif
    end

    // Box latch, write pointer and crop dimensions.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            left_r     <= {XW{1'b0}};
            right_r    <= {XW{1'b0}};
            top_r      <= {YW{1'b0}};
            bot_r      <= {YW{1'b0}};
            ptr_r      <= {(AW+1){1'b0}};
            crop_w_r   <= {(XW+1){1'b0}};
            crop_h_r   <= {(YW+1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if ((state_r == S_IDLE) && start_in) begin
                left_r  <= left_edge;
                right_r <= right_edge;
                top_r   <= top_edge;
                bot_r   <= bot_edge;
            end
            if (start_acc_s) begin
                ptr_r      <= {(AW+1){1'b0}};
                crop_w_r   <= crop_w_s;
                crop_h_r   <= crop_h_s;
                overflow_r <= 1'b0;
            end else begin
                if (wr_s)  ptr_r      <= ptr_r + {{AW{1'b0}}, 1'b1};
                if (ovf_s) overflow_r <= 1'b1;
            end
        end
    end

    // Registered write port and status pulses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {AW{1'b0}};
            wr_data_r <= 16'h0000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            wr_en_r <= wr_s;
            if (wr_s) begin
                wr_addr_r <= ptr_r[AW-1:0];
                wr_data_r <= pixel_in;
            end
            busy_r  <= busy_s;
            done_r  <= done_s;
            error_r <= error_s;
        end
    end

    assign wr_addr_out  = wr_addr_r;
    assign wr_data_out  = wr_data_r;
    assign wr_en_out    = wr_en_r;
    assign busy_out     = busy_r;
    assign done_out     = done_r;
    assign error_out    = error_r;
    assign overflow_out = overflow_r;
    assign crop_w_out   = crop_w_r;
    assign crop_h_out   = crop_h_r;

endmodule

// File: tb/tb_crop_writer.sv
// Scoreboard bench for crop_writer: a default-depth instance and a 4-deep instance
// share one stimulus stream; expected writes are queued as beats are driven.
module tb_crop_writer;
    localparam int XW = 8;
    localparam int YW = 9;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          start_in = 1'b0;
    logic [XW-1:0] left_edge = '0, right_edge = '0, hcount_in = '0;
    logic [YW-1:0] top_edge = '0, bot_edge = '0, vcount_in = '0;
    logic          valid_in = 1'b0;
    logic [15:0]   pixel_in = 16'h0000;

    logic [11:0] wr_addr_a;
    logic [1:0]  wr_addr_b;
    logic [15:0] wr_data_a, wr_data_b;
    logic        wr_en_a, busy_a, done_a, error_a, ovf_a;
    logic        wr_en_b, busy_b, done_b, error_b, ovf_b;
    logic [XW:0] crop_w_a, crop_w_b;
    logic [YW:0] crop_h_a, crop_h_b;

    crop_writer u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .left_edge(left_edge), .right_edge(right_edge), .top_edge(top_edge), .bot_edge(bot_edge),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .valid_in(valid_in), .pixel_in(pixel_in),
        .wr_addr_out(wr_addr_a), .wr_data_out(wr_data_a), .wr_en_out(wr_en_a),
        .busy_out(busy_a), .done_out(done_a), .error_out(error_a), .overflow_out(ovf_a),
        .crop_w_out(crop_w_a), .crop_h_out(crop_h_a)
    );

    crop_writer #(.CROP_DEPTH(4)) u_dut4 (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .left_edge(left_edge), .right_edge(right_edge), .top_edge(top_edge), .bot_edge(bot_edge),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .valid_in(valid_in), .pixel_in(pixel_in),
        .wr_addr_out(wr_addr_b), .wr_data_out(wr_data_b), .wr_en_out(wr_en_b),
        .busy_out(busy_b), .done_out(done_b), .error_out(error_b), .overflow_out(ovf_b),
        .crop_w_out(crop_w_b), .crop_h_out(crop_h_b)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int passes = 0;
    int cyc_n = 0;
    int done_a_cnt = 0, done_b_cnt = 0, err_a_cnt = 0;
    logic [63:0] exp_a[$], obs_a[$], exp_b[$], obs_b[$];

    // Reference model state: 0 idle, 1 armed, 2 capture.
    int m_state = 0;
    int m_l = 0, m_r = 0, m_t = 0, m_b = 0;
    int m_ptr_a = 0, m_ptr_b = 0, m_done = 0;
    bit m_ovf_a = 0, m_ovf_b = 0;

    function automatic int exp_dim(input int lo, input int hi);
`ifdef CROP_WRITER_DECIMATE2_EN
        return (hi - lo) / 2 + 1;
`else
        return hi - lo + 1;
`endif
    endfunction

    task automatic sample();
        if (wr_en_a) obs_a.push_back({32'(cyc_n), 16'(wr_addr_a), wr_data_a});
        if (wr_en_b) obs_b.push_back({32'(cyc_n), 16'(wr_addr_b), wr_data_b});
        done_a_cnt += int'(done_a);
        done_b_cnt += int'(done_b);
        err_a_cnt  += int'(error_a);
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
        cyc_n++;
        sample();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic clear_q();
        exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete();
    endtask

    task automatic do_start(input int l, input int r, input int t, input int b);
        left_edge = XW'(l); right_edge = XW'(r); top_edge = YW'(t); bot_edge = YW'(b);
        start_in = 1'b1;
        if (m_state == 0 && r >= l && b >= t) begin
            m_state = 1; m_l = l; m_r = r; m_t = t; m_b = b;
            m_ptr_a = 0; m_ptr_b = 0; m_ovf_a = 0; m_ovf_b = 0;
        end
        cyc();
        start_in = 1'b0;
    endtask

    task automatic beat(input int h, input int v);
        bit fs, ev, keep;
        logic [15:0] pix;
        pix = 16'(v * 256 + h);
        hcount_in = XW'(h); vcount_in = YW'(v); pixel_in = pix; valid_in = 1'b1;
        fs = (h == 0 && v == 0);
        ev = 0;
        if (m_state == 1 && fs) begin ev = 1; m_state = 2; end
        else if (m_state == 2 && fs) m_state = 0;
        else if (m_state == 2) ev = 1;
`ifdef CROP_WRITER_DECIMATE2_EN
        keep = ((h - m_l) % 2 == 0) && ((v - m_t) % 2 == 0);
`else
        keep = 1;
`endif
        if (ev) begin
            if (h >= m_l && h <= m_r && v >= m_t && v <= m_b && keep) begin
                if (m_ptr_a < 4096) begin
                    exp_a.push_back({32'(cyc_n + 1), 16'(m_ptr_a), pix}); m_ptr_a++;
                end else m_ovf_a = 1;
                if (m_ptr_b < 4) begin
                    exp_b.push_back({32'(cyc_n + 1), 16'(m_ptr_b), pix}); m_ptr_b++;
                end else m_ovf_b = 1;
            end
            if (h == m_r && v == m_b) begin m_state = 0; m_done++; end
        end
        cyc();
        valid_in = 1'b0;
    endtask

    // Raster sweep of ncols columns, ending after beat (last_h, last_v), with idle gaps.
    task automatic run_frame(input int last_v, input int last_h, input int ncols);
        for (int v = 0; v <= last_v; v++) begin
            for (int h = 0; h < ncols; h++) begin
                if (!(v == last_v && h > last_h)) begin
                    if (((h + v) % 5) == 3) cyc();
                    beat(h, v);
                end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({wr_en_a, busy_a, done_a, error_a, ovf_a} !== 5'b0)
            $display("FAIL reset_flags: got %b, expected 00000", {wr_en_a, busy_a, done_a, error_a, ovf_a});
        else passes++;
        checks++;
        if ({crop_w_a, crop_h_a} !== 19'd0)
            $display("FAIL reset_dims: got w=%0d h=%0d, expected 0/0", crop_w_a, crop_h_a);
        else passes++;
        checks++;
        if ({wr_addr_a, wr_data_a} !== 28'd0)
            $display("FAIL reset_port: got addr=%h data=%h, expected 0/0", wr_addr_a, wr_data_a);
        else passes++;
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int d0;
        clear_q();
        d0 = done_a_cnt;
        do_start(10, 13, 5, 6);
        checks++;
        if (busy_a !== 1'b1) $display("FAIL basic_busy: got %b, expected 1", busy_a); else passes++;
        checks++;
        if (crop_w_a !== 9'(exp_dim(10, 13)) || crop_h_a !== 10'(exp_dim(5, 6)))
            $display("FAIL basic_dims: got w=%0d h=%0d, expected %0d/%0d", crop_w_a, crop_h_a,
                     exp_dim(10, 13), exp_dim(5, 6));
        else passes++;
        run_frame(6, 20, 20);
        idle(3);
        checks++;
        if (obs_a.size() !== exp_a.size())
            $display("FAIL basic_count: got %0d writes, expected %0d", obs_a.size(), exp_a.size());
        else passes++;
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            checks++;
            if (obs_a[i] !== exp_a[i])
                $display("FAIL basic_write[%0d]: got cyc/addr/data %0d/%h/%h, expected %0d/%h/%h", i,
                         obs_a[i][63:32], obs_a[i][31:16], obs_a[i][15:0],
                         exp_a[i][63:32], exp_a[i][31:16], exp_a[i][15:0]);
            else passes++;
        end
        checks++;
        if (obs_a.size() > 0 && obs_a[0][15:0] !== 16'h050A)
            $display("FAIL basic_first_pixel: got %h, expected 050a", obs_a[0][15:0]);
        else passes++;
        checks++;
        if (done_a_cnt - d0 !== 1 || busy_a !== 1'b0)
            $display("FAIL basic_done: got %0d pulses busy=%b, expected 1 pulse busy=0", done_a_cnt - d0, busy_a);
        else passes++;
    endtask

    task automatic test_invalid();
        int e0;
        clear_q();
        e0 = err_a_cnt;
        do_start(20, 10, 0, 0);
        checks++;
        if (error_a !== 1'b1 || busy_a !== 1'b0)
            $display("FAIL invalid_err: got err=%b busy=%b, expected 1/0", error_a, busy_a);
        else passes++;
        run_frame(1, 25, 26);
        idle(2);
        checks++;
        if (err_a_cnt - e0 !== 1 || obs_a.size() !== 0 || busy_a !== 1'b0)
            $display("FAIL invalid_quiet: got %0d errs %0d writes busy=%b, expected 1/0/0",
                     err_a_cnt - e0, obs_a.size(), busy_a);
        else passes++;
        checks++;
        if (crop_w_a !== 9'(exp_dim(10, 13)))
            $display("FAIL invalid_dims: got w=%0d, expected %0d", crop_w_a, exp_dim(10, 13));
        else passes++;
    endtask

    task automatic test_overflow();
        int d0;
        clear_q();
        d0 = done_b_cnt;
        do_start(2, 4, 1, 3);
        run_frame(3, 4, 8);
        idle(3);
        checks++;
        if (obs_b.size() !== exp_b.size())
            $display("FAIL ovf_count: got %0d writes, expected %0d", obs_b.size(), exp_b.size());
        else passes++;
        for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
            checks++;
            if (obs_b[i] !== exp_b[i])
                $display("FAIL ovf_write[%0d]: got cyc/addr/data %0d/%h/%h, expected %0d/%h/%h", i,
                         obs_b[i][63:32], obs_b[i][31:16], obs_b[i][15:0],
                         exp_b[i][63:32], exp_b[i][31:16], exp_b[i][15:0]);
            else passes++;
        end
        checks++;
        if (ovf_b !== m_ovf_b || ovf_a !== m_ovf_a)
            $display("FAIL ovf_flag: got small=%b big=%b, expected %b/%b", ovf_b, ovf_a, m_ovf_b, m_ovf_a);
        else passes++;
        checks++;
        if (done_b_cnt - d0 !== 1 || obs_a.size() !== exp_a.size())
            $display("FAIL ovf_done: got %0d pulses %0d big writes, expected 1/%0d",
                     done_b_cnt - d0, obs_a.size(), exp_a.size());
        else passes++;
    endtask

    task automatic test_abort();
        int d0, e0;
        clear_q();
        d0 = done_a_cnt; e0 = err_a_cnt;
        do_start(1, 3, 5, 8);
        run_frame(6, 2, 8);
        do_start(0, 0, 0, 0);
        checks++;
        if (crop_w_a !== 9'(exp_dim(1, 3)) || busy_a !== 1'b1)
            $display("FAIL abort_ignore_start: got w=%0d busy=%b, expected %0d/1", crop_w_a, busy_a, exp_dim(1, 3));
        else passes++;
        beat(0, 0);
        idle(3);
        checks++;
        if (err_a_cnt - e0 !== 1 || busy_a !== 1'b0 || done_a_cnt !== d0)
            $display("FAIL abort_status: got %0d errs busy=%b %0d dones, expected 1/0/0",
                     err_a_cnt - e0, busy_a, done_a_cnt - d0);
        else passes++;
        checks++;
        if (obs_a.size() !== exp_a.size())
            $display("FAIL abort_count: got %0d writes, expected %0d", obs_a.size(), exp_a.size());
        else passes++;
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            checks++;
            if (obs_a[i] !== exp_a[i])
                $display("FAIL abort_write[%0d]: got %h, expected %h", i, obs_a[i], exp_a[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        do_start(0, 7, 2, 3);
        run_frame(2, 2, 16);
        checks++;
        if (obs_a.size() !== 3) $display("FAIL rst_pre_writes: got %0d, expected 3", obs_a.size()); else passes++;
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if ({busy_a, wr_en_a, ovf_a} !== 3'b0 || crop_w_a !== 9'd0 || wr_addr_a !== 12'd0)
            $display("FAIL rst_async: got busy=%b w=%0d addr=%h, expected 0/0/0", busy_a, crop_w_a, wr_addr_a);
        else passes++;
        m_state = 0;
        clear_q();
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(2);
        do_start(0, 7, 2, 3);
        run_frame(3, 7, 16);
        idle(3);
        checks++;
        if (obs_a.size() !== exp_a.size())
            $display("FAIL rst_recap_count: got %0d writes, expected %0d", obs_a.size(), exp_a.size());
        else passes++;
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            checks++;
            if (obs_a[i] !== exp_a[i])
                $display("FAIL rst_recap_write[%0d]: got %h, expected %h", i, obs_a[i], exp_a[i]);
            else passes++;
        end
    endtask

    task automatic test_decimate();
        clear_q();
        do_start(0, 3, 0, 3);
        checks++;
        if (crop_w_a !== 9'(exp_dim(0, 3)) || crop_h_a !== 10'(exp_dim(0, 3)))
            $display("FAIL dec_dims: got w=%0d h=%0d, expected %0d/%0d", crop_w_a, crop_h_a, exp_dim(0, 3), exp_dim(0, 3));
        else passes++;
        run_frame(3, 3, 6);
        idle(3);
        checks++;
        if (obs_a.size() !== exp_a.size())
            $display("FAIL dec_count: got %0d writes, expected %0d", obs_a.size(), exp_a.size());
        else passes++;
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            checks++;
            if (obs_a[i] !== exp_a[i])
                $display("FAIL dec_write[%0d]: got %h, expected %h", i, obs_a[i], exp_a[i]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_decimate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/crop_writer.md
Name: crop_writer

Overview:
- Other end of the card crop path. The card isolator reads a bounding-box region out of a frame buffer; this block writes that region.
- Watches the raster camera pixel stream and captures one frame's worth of pixels inside a programmable bounding box.
- Writes those pixels, packed in raster order from address 0, into a compact crop BRAM port. The card isolator then reads that BRAM.
- Sits between the camera pixel pipeline and the crop buffer; controlled by a start/done handshake.

Parameters:
- WIDTH, 240, frame width in pixels
- HEIGHT, 320, frame height in pixels
- CROP_DEPTH, 4096, crop buffer depth in pixels; AW = $clog2(CROP_DEPTH)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-low
- start_in  input  1  single-cycle request to capture the next frame
- left_edge  input  $clog2(WIDTH)  box left column, inclusive
- right_edge  input  $clog2(WIDTH)  box right column, inclusive
- top_edge  input  $clog2(HEIGHT)  box top row, inclusive
- bot_edge  input  $clog2(HEIGHT)  box bottom row, inclusive
- hcount_in  input  $clog2(WIDTH)  column of the current stream pixel
- vcount_in  input  $clog2(HEIGHT)  row of the current stream pixel
- valid_in  input  1  stream pixel qualifier
- pixel_in  input  16  RGB565 stream pixel
- wr_addr_out  output  AW  crop buffer write address
- wr_data_out  output  16  crop buffer write data
- wr_en_out  output  1  crop buffer write enable
- busy_out  output  1  high in ARMED or CAPTURE
- done_out  output  1  one-cycle pulse on successful completion
- error_out  output  1  one-cycle pulse on rejected start or aborted capture
- overflow_out  output  1  sticky; pixels were dropped in the last capture
- crop_w_out  output  $clog2(WIDTH)+1  latched crop width
- crop_h_out  output  $clog2(HEIGHT)+1  latched crop height

Behaviour:
- Reset (rst_in low, async): state IDLE. All outputs and counters are 0.
- States: IDLE, ARMED, CAPTURE, FINISH.
- IDLE:
  - start_in high latches all four edges.
  - Box validity check: right_edge >= left_edge and bot_edge >= top_edge.
  - Invalid box: error_out pulses on the next cycle; state stays IDLE; crop_w_out/crop_h_out unchanged.
  - Valid box: crop_w_out = right-left+1, crop_h_out = bot-top+1 (zero-extended arithmetic); overflow_out cleared; go to ARMED.
- start_in is ignored in every state other than IDLE.
- ARMED: waits for the frame start, defined as valid_in with hcount_in==0 and vcount_in==0. That beat is evaluated as a CAPTURE pixel in the same cycle; go to CAPTURE.
- CAPTURE, per valid_in beat:
  - A beat is in-box when left<=hcount<=right and top<=vcount<=bot (latched edges).
  - In-box and write pointer < CROP_DEPTH: next cycle drives wr_en_out=1, wr_data_out=pixel_in, wr_addr_out=pointer; pointer then increments.
  - In-box and pointer == CROP_DEPTH: no write; overflow_out set.
  - Write latency is exactly 1 cycle from the accepted valid beat. wr_en_out is low on every other cycle.
  - A beat at (right, bot) ends the capture: go to FINISH.
  - A frame-start beat seen in CAPTURE after the first cycle aborts: no write for that beat; error_out pulses; go to IDLE.
- FINISH: done_out pulses for one cycle; go to IDLE. The final write and done_out land on the same cycle.
- Output timing: busy_out is registered; it is high the cycle after a valid start and low in the cycle done_out or the abort error_out pulses.
- Pointer never wraps; it saturates at CROP_DEPTH.
- The start in-box check uses the latched edges, not the live edge inputs.
- A reset mid-capture returns to IDLE immediately; the partially written buffer contents are left as-is.

Optional Feature:
- Macro: CROP_WRITER_DECIMATE2_EN
- Defined:
  - Only in-box beats with (hcount-left) even and (vcount-top) even are written.
  - crop_w_out = (right-left)/2+1 and crop_h_out = (bot-top)/2+1.
  - Completion is still triggered by the beat at (right, bot); that beat is written only if it meets the parity rule.
- Undefined: every in-box pixel is written.

Test Plan:
- Box L=10,R=13,T=5,B=6, one full frame with pixel=vcount*256+hcount -> 8 writes, addrs 0..7, data 0x050A..0x050D then 0x060A..0x060D; done_out once; crop_w=4, crop_h=2.
- start_in with L=20,R=10 -> error_out pulses, state stays IDLE, no writes, busy_out stays 0.
- CROP_DEPTH=4, box 3x3 -> writes to addrs 0..3 only; overflow_out=1; done_out still pulses after (R,B).
- Frame restarted (0,0 beat) at row 6 of a box T=5,B=8 -> error_out pulse, IDLE; a second start_in while busy is ignored.
- rst_in driven low mid-capture after 3 writes -> all outputs 0 asynchronously; a new start then captures correctly from addr 0.
- DECIMATE2_EN, box L=0,R=3,T=0,B=3 -> 4 writes of (0,0),(2,0),(0,2),(2,2); crop_w=2, crop_h=2.
